tetris_fall_timer: RTL and testbench
====================================

Name: tetris_fall_timer

Overview:
Parametrised gravity and game-speed controller for the tetris top level. It produces the one-cycle next_fall strobe that drives tetris_engine. It adds level-based speed-up from the lines-cleared count, hard-drop pacing, and pause. It also handles start gating and game-over freeze.

Parameters:
CountWidth, 24, width of the fall-period counter and of the period values.
LinesWidth, 21, width of the lines_cleared input.
LevelWidth, 4, width of the level output.
BasePeriod, 8000000, fall period in clk cycles at level 0.
PeriodStep, 600000, period reduction per level.
MinPeriod, 800000, floor for the fall period.
NumLevels, 10, number of levels; the highest level is NumLevels-1.
LinesPerLevel, 10, lines cleared per level-up.
DropPeriod, 4, cycles between fall strobes during a hard drop; must be >= 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; asserted together with the engine's reset_game
start  in  1  any player input; starts the game from IDLE
move_down  in  1  soft-drop request (single-cycle pulse)
drop  in  1  hard-drop request (single-cycle pulse)
pause  in  1  pause toggle (single-cycle pulse)
fallen  in  1  engine: piece has landed
game_over  in  1  engine: game over
lines_cleared  in  LinesWidth  engine: total lines cleared
next_fall  out  1  one-cycle fall strobe to the engine
level  out  LevelWidth  current level
period  out  CountWidth  current fall period
dropping  out  1  high while in DROP
running  out  1  high in RUN or DROP

Behaviour:
- The block has one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, count=0, level=0, threshold=LinesPerLevel, period=BasePeriod, next_fall=0, dropping=0, running=0.
- All outputs are registered. next_fall is asserted for exactly one cycle, one cycle after the causing event.
- States:
  - IDLE: the counter is held at 0 and no strobes are produced. start=1 moves to RUN; move_down or drop also count as start.
  - RUN: count increments each cycle. When count==period-1, count wraps to 0 and next_fall pulses.
    - move_down=1: next_fall pulses and count is cleared to 0.
    - drop=1: go to DROP and clear the drop counter.
  - DROP: next_fall pulses every DropPeriod cycles; the first pulse comes DropPeriod cycles after entry.
    - fallen=1: go to RUN with count=0. No strobe is issued in that cycle, even if one was due.
    - move_down and drop are ignored.
  - PAUSED: all counters are frozen and no strobes are produced. pause=1 returns to the saved state (RUN or DROP) with counters unchanged.
  - OVER: terminal state with no strobes. level and period are frozen. Only reset leaves OVER.
- Event priority when several occur in the same cycle: reset > game_over > pause > fallen > drop > move_down > timer expiry.
  - pause in IDLE is ignored.
  - game_over moves any state to OVER.
  - A timer expiry in the same cycle as move_down produces a single pulse.
- Level:
  - Whenever lines_cleared >= threshold and level < NumLevels-1: level increments and threshold += LinesPerLevel.
  - Level rises by at most one step per cycle, so a multi-line jump takes several cycles. No divider is used.
  - Level updates in all states except OVER.
- Period:
  - period is registered one cycle after a level change.
  - period = max(BasePeriod - level*PeriodStep, MinPeriod), computed without unsigned underflow.
  - If period drops below count+1, the next cycle expires: it pulses and wraps to 0.
- Widths: threshold is LinesWidth+1 bits to avoid wrap. Unsigned comparisons are used throughout.
- Reset mid-DROP or mid-PAUSED returns to the full reset values. The engine must be reset in the same cycle.

Test Plan:
(Bench parameters: BasePeriod=20, PeriodStep=4, MinPeriod=8, NumLevels=4, LinesPerLevel=2, DropPeriod=3.)
- Start and gravity: reset, then start pulse at cycle 0 → next_fall pulses exactly every 20 cycles; no pulse before start; running=1.
- Soft drop: in RUN at count=10, pulse move_down → next_fall on the next cycle; the following pulse comes 20 cycles after that.
- Level curve: step lines_cleared 0→1→2→4→6→20 → level 0,0,1,2,3,3 and period 20,20,16,12,8,8. A jump 0→6 gives level=3 within 3 cycles.
- Hard drop: pulse drop → dropping=1 and next_fall every 3 cycles. Assert fallen on the same cycle a pulse is due → no pulse, dropping=0, gravity restarts from count 0.
- Pause: pulse pause in RUN at count=7 → no strobes for 100 cycles. Pulse pause again → next pulse after 13 more cycles.
- Game over and reset: game_over during DROP → next_fall stays 0, running=0, state persists. Reset → all reset values; start is required again.

Source files
------------

// File: rtl/tetris_fall_timer.sv
// Gravity and game-speed controller for the tetris top level.
// Emits the one-cycle next_fall strobe and tracks level and fall period.
module tetris_fall_timer #(
  parameter int unsigned CountWidth    = 24,
  parameter int unsigned LinesWidth    = 21,
  parameter int unsigned LevelWidth    = 4,
  parameter int unsigned BasePeriod    = 8000000,
  parameter int unsigned PeriodStep    = 600000,
  parameter int unsigned MinPeriod     = 800000,
  parameter int unsigned NumLevels     = 10,
  parameter int unsigned LinesPerLevel = 10,
  parameter int unsigned DropPeriod    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  move_down,
  input  logic                  drop,
  input  logic                  pause,
  input  logic                  fallen,
  input  logic                  game_over,
  input  logic [LinesWidth-1:0] lines_cleared,
  output logic                  next_fall,
  output logic [LevelWidth-1:0] level,
  output logic [CountWidth-1:0] period,
  output logic                  dropping,
  output logic                  running
);

  localparam int unsigned DW = (DropPeriod > 1) ? $clog2(DropPeriod) : 1;
  localparam int unsigned PW = CountWidth + LevelWidth + 1;
  localparam int unsigned TW = LinesWidth + 1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DROP,
    PAUSED,
    OVER
  } state_t;

  state_t                state_q, state_d;
  state_t                saved_q, saved_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [DW-1:0]         dcount_q, dcount_d;
  logic                  fall_d;
  logic [CountWidth:0]   count_inc;
  logic                  expire;
  logic                  dexpire;
  logic                  go;
  logic [TW-1:0]         threshold;
  logic                  level_up;
  logic [PW-1:0]         red;
  logic [PW-1:0]         floor_w;
  logic [CountWidth-1:0] period_d;

  // A period shrinking below count+1 still expires on the next cycle.
  assign count_inc = {1'b0, count_q} + (CountWidth+1)'(1);
  assign expire    = count_inc >= {1'b0, period};
  assign dexpire   = dcount_q >= DW'(DropPeriod - 1);
  assign go        = start | move_down | drop;

  assign level_up = ({1'b0, lines_cleared} >= threshold)
                  && (level < LevelWidth'(NumLevels - 1));

  // Clamp against the floor before subtracting so nothing underflows.
  assign red      = PW'(level) * PW'(PeriodStep);
  assign floor_w  = PW'(MinPeriod) + red;
  assign period_d = (PW'(BasePeriod) > floor_w)
                  ? CountWidth'(PW'(BasePeriod) - red)
                  : CountWidth'(MinPeriod);

  // Next-state and strobe decode in event priority order.
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    count_d  = count_q;
    dcount_d = dcount_q;
    fall_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (game_over) begin
          state_d = OVER;
        end else if (go) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = OVER;
        end else if (pause) begin
          state_d = PAUSED;
          saved_d = RUN;
        end else if (drop) begin
          state_d  = DROP;
          dcount_d = '0;
        end else if (move_down || expire) begin
          fall_d  = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + CountWidth'(1);
        end
      end
      DROP: begin
        if (game_over) begin
          state_d = OVER;
        end else if (pause) begin
          state_d = PAUSED;
          saved_d = DROP;
        end else if (fallen) begin
          state_d = RUN;
          count_d = '0;
        end else if (dexpire) begin
          fall_d   = 1'b1;
          dcount_d = '0;
        end else begin
          dcount_d = dcount_q + DW'(1);
        end
      end
      PAUSED: begin
        if (game_over) begin
          state_d = OVER;
        end else if (pause) begin
          state_d = saved_q;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      saved_q   <= RUN;
      count_q   <= '0;
      dcount_q  <= '0;
      next_fall <= 1'b0;
      dropping  <= 1'b0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      count_q   <= count_d;
      dcount_q  <= dcount_d;
      next_fall <= fall_d;
      dropping  <= (state_d == DROP);
      running   <= (state_d == RUN) || (state_d == DROP);
    end
  end

  // Level steps at most once per cycle; period follows a cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      level     <= '0;
      threshold <= TW'(LinesPerLevel);
      period    <= CountWidth'(BasePeriod);
    end else if (state_q != OVER) begin
      period <= period_d;
      if (level_up) begin
        level     <= level + LevelWidth'(1);
        threshold <= threshold + TW'(LinesPerLevel);
      end
    end
  end

endmodule

// File: tb/tb_tetris_fall_timer.sv
// Bench for tetris_fall_timer: reference model plus directed scenarios.
// Inputs change on the falling edge; outputs are checked there too.
module tb_tetris_fall_timer;

  localparam int BP  = 20;
  localparam int PS  = 4;
  localparam int MP  = 8;
  localparam int NL  = 4;
  localparam int LPL = 2;
  localparam int DP  = 3;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DROP  = 2;
  localparam int S_PAUSE = 3;
  localparam int S_OVER  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        move_down = 1'b0;
  logic        drop = 1'b0;
  logic        pause = 1'b0;
  logic        fallen = 1'b0;
  logic        game_over = 1'b0;
  logic [20:0] lines_cleared = '0;
  logic        next_fall;
  logic [3:0]  level;
  logic [23:0] period;
  logic        dropping;
  logic        running;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  tetris_fall_timer #(
    .CountWidth(24),
    .LinesWidth(21),
    .LevelWidth(4),
    .BasePeriod(BP),
    .PeriodStep(PS),
    .MinPeriod(MP),
    .NumLevels(NL),
    .LinesPerLevel(LPL),
    .DropPeriod(DP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .move_down(move_down),
    .drop(drop),
    .pause(pause),
    .fallen(fallen),
    .game_over(game_over),
    .lines_cleared(lines_cleared),
    .next_fall(next_fall),
    .level(level),
    .period(period),
    .dropping(dropping),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Reference model: game rules in plain integers.
  int ms, msv, mc, mdc, ml, mt, mp, mnf, mdr, mrun;

  always @(posedge clk) begin
    int np;
    int os;
    if (reset) begin
      ms = S_IDLE; msv = S_RUN; mc = 0; mdc = 0;
      ml = 0; mt = LPL; mp = BP;
      mnf = 0; mdr = 0; mrun = 0;
    end else begin
      os  = ms;
      np  = (BP - ml * PS > MP) ? BP - ml * PS : MP;
      mnf = 0;
      if (ms != S_OVER && game_over) begin
        ms = S_OVER;
      end else begin
        case (ms)
          S_IDLE: begin
            mc = 0;
            if (start || move_down || drop) ms = S_RUN;
          end
          S_RUN: begin
            if (pause) begin
              msv = S_RUN; ms = S_PAUSE;
            end else if (drop) begin
              ms = S_DROP; mdc = 0;
            end else if (move_down || mc + 1 >= mp) begin
              mnf = 1; mc = 0;
            end else begin
              mc++;
            end
          end
          S_DROP: begin
            if (pause) begin
              msv = S_DROP; ms = S_PAUSE;
            end else if (fallen) begin
              ms = S_RUN; mc = 0;
            end else if (mdc + 1 >= DP) begin
              mnf = 1; mdc = 0;
            end else begin
              mdc++;
            end
          end
          S_PAUSE: begin
            if (pause) ms = msv;
          end
          default: ;
        endcase
      end
      if (os != S_OVER) begin
        mp = np;
        if (int'(lines_cleared) >= mt && ml < NL - 1) begin
          ml++; mt += LPL;
        end
      end
      mdr  = (ms == S_DROP) ? 1 : 0;
      mrun = (ms == S_RUN || ms == S_DROP) ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_next_fall", next_fall, mnf);
      chk("m_level", level, ml);
      chk("m_period", period, mp);
      chk("m_dropping", dropping, mdr);
      chk("m_running", running, mrun);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_count(int n, output int p);
    p = 0;
    repeat (n) begin
      @(negedge clk);
      if (next_fall) p++;
    end
  endtask

  task automatic wait_pulse(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (next_fall) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    tick(2);
    chk("rst_next_fall", next_fall, 0);
    chk("rst_level", level, 0);
    chk("rst_period", period, 20);
    chk("rst_dropping", dropping, 0);
    chk("rst_running", running, 0);
    chk_en = 1'b1;
    reset = 1'b0;

    tick_count(5, n);
    chk("idle_no_pulse", n, 0);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_running", running, 1);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(n);
      chk("gravity_gap", n, 20);
    end

    tick(10);
    move_down = 1'b1;
    tick(1);
    move_down = 1'b0;
    chk("soft_pulse", next_fall, 1);
    wait_pulse(n);
    chk("soft_next_gap", n, 20);

    tick(7);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    chk("pause_running", running, 0);
    tick_count(100, n);
    chk("pause_quiet", n, 0);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    wait_pulse(n);
    chk("resume_gap", n, 13);

    drop = 1'b1;
    tick(1);
    drop = 1'b0;
    chk("drop_dropping", dropping, 1);
    wait_pulse(n);
    chk("drop_gap1", n, 3);
    wait_pulse(n);
    chk("drop_gap2", n, 3);
    tick(2);
    fallen = 1'b1;
    tick(1);
    fallen = 1'b0;
    chk("fallen_no_pulse", next_fall, 0);
    chk("fallen_dropping", dropping, 0);
    chk("fallen_running", running, 1);
    wait_pulse(n);
    chk("fallen_gravity_gap", n, 20);

    lines_cleared = 21'd1; tick(3);
    chk("lv_l1", level, 0);
    chk("lv_p1", period, 20);
    lines_cleared = 21'd2; tick(3);
    chk("lv_l2", level, 1);
    chk("lv_p2", period, 16);
    lines_cleared = 21'd4; tick(3);
    chk("lv_l4", level, 2);
    chk("lv_p4", period, 12);
    lines_cleared = 21'd6; tick(3);
    chk("lv_l6", level, 3);
    chk("lv_p6", period, 8);
    lines_cleared = 21'd20; tick(3);
    chk("lv_l20", level, 3);
    chk("lv_p20", period, 8);

    drop = 1'b1;
    tick(1);
    drop = 1'b0;
    tick(1);
    game_over = 1'b1;
    tick(1);
    game_over = 1'b0;
    chk("over_running", running, 0);
    chk("over_dropping", dropping, 0);
    tick_count(20, n);
    chk("over_quiet", n, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("over_stays", running, 0);
    chk("over_level", level, 3);
    chk("over_period", period, 8);

    reset = 1'b1;
    lines_cleared = '0;
    tick(1);
    reset = 1'b0;
    chk("rst2_level", level, 0);
    chk("rst2_period", period, 20);
    chk("rst2_running", running, 0);
    tick_count(25, n);
    chk("rst2_needs_start", n, 0);
    chk("rst2_idle", running, 0);

    lines_cleared = 21'd6;
    tick(1);
    chk("jump_c1", level, 1);
    tick(1);
    chk("jump_c2", level, 2);
    tick(1);
    chk("jump_c3", level, 3);
    tick(2);
    chk("jump_period", period, 8);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_pulse(n);
    chk("fast_gap", n, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
